seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request a divide; sampled only on rising clk edges.
REQ-004 dividend  input  8  unsigned dividend; captured on the accepting edge.
REQ-005 divisor  input  4  unsigned divisor; captured on the accepting edge.
REQ-006 quotient  output  8  unsigned quotient; registered.
REQ-007 remainder  output  4  unsigned remainder; registered.
REQ-008 busy  output  1  high while a divide is in progress.
REQ-009 done  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-010 div_by_zero  output  1  status flag of the last completed operation; divisor was 0.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-012 Start SHALL be accepted only in IDLE or DONE (start high at a rising edge).
- Acceptance latches dividend and divisor into internal registers.
- Acceptance clears the working remainder (5 bits) and the iteration counter (3 bits).
REQ-013 Divisor != 0 on acceptance: next state SHALL be CALC, busy=1, done=0.
REQ-014 CALC SHALL perform exactly one restoring-division step per clock, MSB of the dividend first. Each step:
- r = {r[3:0], next dividend bit};
- if r >= divisor: r = r - divisor and the quotient bit is 1; otherwise the quotient bit is 0.
REQ-015 On the 8th CALC edge, the block SHALL:
- load quotient and remainder (low 4 bits of r);
- clear div_by_zero;
- enter DONE with done=1 and busy=0.
REQ-016 Latency: done SHALL be high in the 8th cycle after the accepting edge.
REQ-017 Divisor == 0 on acceptance: the block SHALL skip CALC and enter DONE on the next edge. It loads quotient=8'hFF, remainder=dividend[3:0] and div_by_zero=1. Latency is 1 cycle.
REQ-018 DONE SHALL last one cycle and then return to IDLE, unless start is high, in which case the new operation is accepted per REQ-012.
REQ-019 Start while busy (CALC) SHALL be ignored, and changes on dividend/divisor during CALC SHALL have no effect.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next completion; they do not change during CALC.
REQ-021 The arithmetic SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.
REQ-022 The working remainder SHALL be 5 bits wide so that the shifted value (max 29) never overflows.

Reset
REQ-023 rst_n low SHALL immediately force the following, independent of clk:
- state=IDLE;
- quotient=0, remainder=0;
- busy=0, done=0, div_by_zero=0;
- internal counter and registers cleared.
REQ-024 Reset asserted mid-CALC SHALL abort the operation, with no done pulse after release.
REQ-025 After rst_n rises, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- dividend=200, divisor=7 -> 8 cycles later done=1, quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=15 -> quotient=17, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=100, divisor=0 -> done one cycle after acceptance, quotient=8'hFF, remainder=4, div_by_zero=1; next valid divide clears div_by_zero.
- Start 200/7, then pulse start with 50/3 during CALC -> result is 28/4; only one done pulse.
- Start held high across DONE with new operands 9/2 -> back-to-back accept, second done gives quotient=4, remainder=1.
- rst_n low at CALC cycle 4 -> all outputs 0 asynchronously, no done afterwards; a fresh 200/7 completes correctly.
REQ-027 The bench SHALL exhaustively compare all 4096 dividend/divisor pairs against a reference model and check REQ-016 latency on each.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : 8-bit by 4-bit unsigned restoring divider, one quotient bit per
//            clock (MSB first). A zero divisor completes in one cycle with a
//            saturated quotient and a status flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_nextState;

    // Dividend bits shift out of the top while quotient bits shift in below,
    // so after eight steps this register holds the quotient.
    logic [7:0] r_dvdShift;
    logic [3:0] r_divisor;
    // Partial remainder between steps is always < divisor, so 4 bits suffice
    // for storage; the 5-bit shifted working value below cannot overflow.
    logic [3:0] r_partRem;
    logic [2:0] r_count;

    logic       w_accept;
    logic       w_lastStep;
    logic [4:0] w_workRem;
    logic       w_fits;
    logic [4:0] w_remStep;

    // Acceptance, last-step detection and one restoring-division step
    always_comb begin
        w_accept   = start && ((r_state == c_IDLE) || (r_state == c_DONE));
        w_lastStep = (r_state == c_CALC) && (r_count == 3'd7);
        w_workRem  = {r_partRem, r_dvdShift[7]};
        w_fits     = (w_workRem >= {1'b0, r_divisor});
        w_remStep  = w_fits ? (w_workRem - {1'b0, r_divisor}) : w_workRem;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a zero divisor bypasses CALC entirely
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_nextState = (divisor == 4'd0) ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (w_lastStep) begin
                    w_nextState = c_DONE;
                end
            end
            c_DONE: begin
                if (w_accept) begin
                    w_nextState = (divisor == 4'd0) ? c_DONE : c_CALC;
                end else begin
                    w_nextState = c_IDLE;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (r_state == c_CALC);
        done = (r_state == c_DONE);
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvdShift  <= 8'd0;
            r_divisor   <= 4'd0;
            r_partRem   <= 4'd0;
            r_count     <= 3'd0;
            quotient    <= 8'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dvdShift <= dividend;
            r_divisor  <= divisor;
            r_partRem  <= 4'd0;
            r_count    <= 3'd0;
            if (divisor == 4'd0) begin
                quotient    <= 8'hFF;
                remainder   <= dividend[3:0];
                div_by_zero <= 1'b1;
            end
        end else if (r_state == c_CALC) begin
            r_dvdShift <= {r_dvdShift[6:0], w_fits};
            r_partRem  <= w_remStep[3:0];
            r_count    <= r_count + 3'd1;
            if (w_lastStep) begin
                quotient    <= {r_dvdShift[6:0], w_fits};
                remainder   <= w_remStep[3:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Scoreboard bench for seq_divider: directed scenarios, exhaustive
//            operand sweep and random traffic against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [3:0] divisor = 4'd0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         doneCyc;
        int         a;
        int         b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] lastQ = 8'd0;
    logic [3:0] lastR = 4'd0;
    logic       lastDz = 1'b0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division; zero divisor saturates
    function automatic exp_t model(input int a, input int b, input int dc);
        exp_t e;
        e.a = a;
        e.b = b;
        e.doneCyc = dc;
        if (b == 0) begin
            e.q  = 8'hFF;
            e.r  = a[3:0];
            e.dz = 1'b1;
        end else begin
            e.q  = 8'(a / b);
            e.r  = 4'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge while the DUT is idle or showing done
    task automatic issue(input int a, input int b);
        dividend = 8'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        sb.push_back(model(a, b, cyc + 1 + ((b == 0) ? 0 : 8)));
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout %s: done=%0b after 12 cycles, required done=1", tag, done);
            sb.delete();
        end
    endtask

    task automatic chkZero(input string tag);
        checks++;
        if (quotient !== 8'd0 || remainder !== 4'd0 || busy !== 1'b0 ||
            done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s: q=%0d r=%0d busy=%0b done=%0b dz=%0b, required all 0",
                     tag, quotient, remainder, busy, done, div_by_zero);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse; results must hold while busy
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_done: done=1 at cycle %0d, required no pulse", cyc);
                    end else begin
                        e = sb.pop_front();
                        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) begin
                            errors++;
                            $display("FAIL result %0d/%0d: got q=%0d r=%0d dz=%0b, required q=%0d r=%0d dz=%0b",
                                     e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                        end
                        checks++;
                        if (cyc != e.doneCyc) begin
                            errors++;
                            $display("FAIL latency %0d/%0d: done at cycle %0d, required cycle %0d",
                                     e.a, e.b, cyc, e.doneCyc);
                        end
                        lastQ  = e.q;
                        lastR  = e.r;
                        lastDz = e.dz;
                    end
                end else if (busy) begin
                    checks++;
                    if ({quotient, remainder, div_by_zero} !== {lastQ, lastR, lastDz}) begin
                        errors++;
                        $display("FAIL hold: got q=%0d r=%0d dz=%0b during CALC, required q=%0d r=%0d dz=%0b",
                                 quotient, remainder, div_by_zero, lastQ, lastR, lastDz);
                    end
                end
            end
        end
    end

    initial begin
        #3 rst_n = 1'b0;
        #1 chkZero("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First start right after release must be accepted immediately
        issue(200, 7);  waitDone("200/7");
        @(negedge clk);
        issue(255, 15); waitDone("255/15");
        issue(5, 9);    waitDone("5/9");
        @(negedge clk);
        issue(100, 0);  waitDone("100/0");
        issue(200, 7);  waitDone("dz_clear");
        @(negedge clk);

        // Start pulse with new operands during CALC is ignored
        issue(200, 7);
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("calc_start_ignored");
        repeat (3) @(negedge clk);

        // Start held high through CALC and DONE: second op accepted back-to-back
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        sb.push_back(model(200, 7, cyc + 9));
        @(negedge clk);
        dividend = 8'd9;
        divisor  = 4'd2;
        sb.push_back(model(9, 2, cyc + 17));
        waitDone("b2b_first");
        @(negedge clk);
        start = 1'b0;
        waitDone("b2b_second");
        @(negedge clk);

        // Reset in the middle of CALC aborts without a done pulse
        issue(200, 7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        lastQ  = 8'd0;
        lastR  = 4'd0;
        lastDz = 1'b0;
        #1 chkZero("reset_midcalc");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(200, 7); waitDone("after_reset");
        @(negedge clk);

        // Exhaustive sweep, randomly mixing back-to-back and gapped starts
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                issue(a, b);
                waitDone("sweep");
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end

        // Random traffic
        repeat (200) begin
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            waitDone("random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d results never delivered, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
